// File: rtl/fft_pkg.sv
// Shared widths and payload types for the FFT power path and the LED view.
package fft_pkg;

  localparam int unsigned N      = 1024;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned POW_W  = 2 * DATA_W + 1;
  localparam int unsigned IDX_W  = $clog2(N);

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } cplx_t;

  typedef logic [POW_W-1:0] pow_t;
  typedef logic [IDX_W-1:0] idx_t;

  // Positive-frequency bins eligible for the peak search (DC excluded).
  function automatic logic is_search_bin(input idx_t idx);
    return (idx >= IDX_W'(1)) && (idx <= IDX_W'(N / 2 - 1));
  endfunction

endpackage

// File: rtl/power_pipe.sv
// Three-stage valid/stall pipeline: register sample, square re and im, sum.
module power_pipe
  import fft_pkg::*;
(
  input  logic  i_clk,
  input  logic  i_rst_n,
  input  logic  i_stall,
  input  logic  i_valid,
  input  cplx_t i_data,
  input  idx_t  i_index,
  output logic  o_valid,
  output pow_t  o_data,
  output idx_t  o_index
);

  logic              r_s1_valid;
  cplx_t             r_s1_data;
  idx_t              r_s1_index;
  logic              r_s2_valid;
  logic [PROD_W-1:0] r_s2_re_sq;
  logic [PROD_W-1:0] r_s2_im_sq;
  idx_t              r_s2_index;
  logic              r_s3_valid;
  pow_t              r_s3_pow;
  idx_t              r_s3_index;

  logic signed [PROD_W-1:0] w_re_ext;
  logic signed [PROD_W-1:0] w_im_ext;
  logic signed [PROD_W-1:0] w_re_sq;
  logic signed [PROD_W-1:0] w_im_sq;

  // Squares of DATA_W signed values are non-negative and fit in PROD_W bits.
  assign w_re_ext = {{DATA_W{r_s1_data.re[DATA_W-1]}}, r_s1_data.re};
  assign w_im_ext = {{DATA_W{r_s1_data.im[DATA_W-1]}}, r_s1_data.im};
  assign w_re_sq  = w_re_ext * w_re_ext;
  assign w_im_sq  = w_im_ext * w_im_ext;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s3_valid <= 1'b0;
    end else if (!i_stall) begin
      r_s1_valid <= i_valid;
      r_s2_valid <= r_s1_valid;
      r_s3_valid <= r_s2_valid;
    end
  end

  // Payload registers hold while stalled so the output stays stable.
  always_ff @(posedge i_clk) begin
    if (!i_stall) begin
      r_s1_data  <= i_data;
      r_s1_index <= i_index;
      r_s2_re_sq <= w_re_sq;
      r_s2_im_sq <= w_im_sq;
      r_s2_index <= r_s1_index;
      r_s3_pow   <= POW_W'(r_s2_re_sq) + POW_W'(r_s2_im_sq);
      r_s3_index <= r_s2_index;
    end
  end

  assign o_valid = r_s3_valid;
  assign o_data  = r_s3_pow;
  assign o_index = r_s3_index;

endmodule

// File: rtl/fft_power_stage.sv
// FFT output to per-bin power stream, with bin tagging, resync and per-frame peak.
module fft_power_stage
  import fft_pkg::*;
(
  input  logic  i_slow_clk,
  input  logic  i_reset_n,
  input  cplx_t i_fft_in_data,
  input  logic  i_fft_in_valid,
  output logic  o_fft_in_ready,
  output pow_t  o_fft_out_data,
  output idx_t  o_fft_out_index,
  output logic  o_fft_out_valid,
  input  logic  i_fft_out_ready,
  input  logic  i_resync,
  output logic  o_frame_done,
  output idx_t  o_peak_index,
  output pow_t  o_peak_value
);

  idx_t r_bin;
  idx_t r_max_index;
  pow_t r_max_value;
  idx_t r_peak_index;
  pow_t r_peak_value;

  logic w_stall;
  logic w_accept;
  logic w_xfer;
  idx_t w_tag;

  assign w_stall        = o_fft_out_valid & ~i_fft_out_ready;
  assign o_fft_in_ready = ~w_stall;
  assign w_accept       = i_fft_in_valid & o_fft_in_ready;
  assign w_xfer         = o_fft_out_valid & i_fft_out_ready;
  assign w_tag          = i_resync ? '0 : r_bin;
  assign o_frame_done   = w_xfer & (o_fft_out_index == IDX_W'(N - 1));

  // A resync coincident with an accept tags that sample as bin 0.
  always_ff @(posedge i_slow_clk) begin
    if (!i_reset_n) begin
      r_bin <= '0;
    end else if (w_accept) begin
      r_bin <= w_tag + IDX_W'(1);
    end else if (i_resync) begin
      r_bin <= '0;
    end
  end

  power_pipe u_power_pipe (
    .i_clk   (i_slow_clk),
    .i_rst_n (i_reset_n),
    .i_stall (w_stall),
    .i_valid (w_accept),
    .i_data  (i_fft_in_data),
    .i_index (w_tag),
    .o_valid (o_fft_out_valid),
    .o_data  (o_fft_out_data),
    .o_index (o_fft_out_index)
  );

  // Running max is seeded by bin 1; strict compare keeps the lowest index on ties.
  always_ff @(posedge i_slow_clk) begin
    if (!i_reset_n) begin
      r_max_index  <= '0;
      r_max_value  <= '0;
      r_peak_index <= '0;
      r_peak_value <= '0;
    end else if (w_xfer) begin
      if (o_fft_out_index == IDX_W'(1)) begin
        r_max_index <= o_fft_out_index;
        r_max_value <= o_fft_out_data;
      end else if (is_search_bin(o_fft_out_index) && (o_fft_out_data > r_max_value)) begin
        r_max_index <= o_fft_out_index;
        r_max_value <= o_fft_out_data;
      end
      if (o_frame_done) begin
        r_peak_index <= r_max_index;
        r_peak_value <= r_max_value;
      end
    end
  end

  assign o_peak_index = r_peak_index;
  assign o_peak_value = r_peak_value;

endmodule

// File: tb/tb_fft_power_stage.sv
// Scoreboard bench for fft_power_stage: directed vectors, random handshakes, resync and reset.
module tb_fft_power_stage;
  import fft_pkg::*;

  typedef struct packed {
    pow_t data;
    idx_t idx;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  cplx_t in_data = '0;
  logic  in_valid = 1'b0;
  logic  in_ready;
  pow_t  out_data;
  idx_t  out_index;
  logic  out_valid;
  logic  out_ready = 1'b1;
  logic  resync = 1'b0;
  logic  frame_done;
  idx_t  peak_index;
  pow_t  peak_value;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   rdy_mode = 0;
  idx_t tb_bin = '0;

  int   t_acc = 0, t_out = 0, t_last = 0, n_out = 0, fd_count = 0;
  logic arm_lat = 1'b0, arm_out = 1'b0;

  idx_t m_max_idx = '0, m_pk_idx = '0;
  pow_t m_max_val = '0, m_pk_val = '0;
  logic prev_stall = 1'b0;
  pow_t prev_data = '0;
  idx_t prev_idx = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fft_power_stage dut (
    .i_slow_clk      (clk),
    .i_reset_n       (rst_n),
    .i_fft_in_data   (in_data),
    .i_fft_in_valid  (in_valid),
    .o_fft_in_ready  (in_ready),
    .o_fft_out_data  (out_data),
    .o_fft_out_index (out_index),
    .o_fft_out_valid (out_valid),
    .i_fft_out_ready (out_ready),
    .i_resync        (resync),
    .o_frame_done    (frame_done),
    .o_peak_index    (peak_index),
    .o_peak_value    (peak_value)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, expv, cyc);
    end
  endtask

  // One clock of stimulus; expected result is queued when the accept is seen.
  task automatic drive(input logic v, input logic signed [DATA_W-1:0] re,
                       input logic signed [DATA_W-1:0] im, input pow_t expv,
                       input logic rs, output logic acc);
    exp_t e;
    idx_t tag;
    @(posedge clk);
    #1;
    in_valid   = v;
    in_data.re = re;
    in_data.im = im;
    resync     = rs;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
    @(negedge clk);
    acc = v && in_ready && rst_n;
    if (acc) begin
      tag    = rs ? '0 : tb_bin;
      e.data = expv;
      e.idx  = tag;
      exp_q.push_back(e);
      tb_bin = IDX_W'(tag + IDX_W'(1));
      if (arm_lat) begin
        t_acc   = cyc;
        arm_lat = 1'b0;
      end
    end else if (rs) begin
      tb_bin = '0;
    end
  endtask

  task automatic drain();
    logic a;
    int   k;
    rdy_mode = 0;
    k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      drive(1'b0, '0, '0, '0, 1'b0, a);
      k++;
    end
    chk("drain_empty", 128'(exp_q.size()), 128'(0));
    repeat (2) drive(1'b0, '0, '0, '0, 1'b0, a);
  endtask

  // Monitor: pops the scoreboard on every output transfer and tracks the expected peak.
  always @(negedge clk) begin
    exp_t e;
    logic popped;
    logic fd_exp;
    popped = 1'b0;
    fd_exp = 1'b0;
    if (prev_stall) begin
      chk("stall_valid_held", 128'(out_valid), 128'(1));
      chk("stall_data_held", 128'(out_data), 128'(prev_data));
      chk("stall_index_held", 128'(out_index), 128'(prev_idx));
    end
    if (out_valid && out_ready) begin
      chk("sb_has_entry", 128'(exp_q.size() > 0), 128'(1));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        popped = 1'b1;
        chk("out_data", 128'(out_data), 128'(e.data));
        chk("out_index", 128'(out_index), 128'(e.idx));
        fd_exp = (e.idx == IDX_W'(N - 1));
        n_out++;
        t_last = cyc;
      end
    end
    if (out_valid && arm_out) begin
      t_out   = cyc;
      arm_out = 1'b0;
    end
    chk("frame_done", 128'(frame_done), 128'(fd_exp));
    if (frame_done) fd_count++;
    chk("peak_index", 128'(peak_index), 128'(m_pk_idx));
    chk("peak_value", 128'(peak_value), 128'(m_pk_val));
    if (popped) begin
      if (e.idx == IDX_W'(1)) begin
        m_max_idx = e.idx;
        m_max_val = e.data;
      end else if (e.idx > IDX_W'(1) && e.idx < IDX_W'(N / 2) && e.data > m_max_val) begin
        m_max_idx = e.idx;
        m_max_val = e.data;
      end
      if (fd_exp) begin
        m_pk_idx = m_max_idx;
        m_pk_val = m_max_val;
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    prev_idx   = out_index;
    if (!rst_n) begin
      exp_q.delete();
      m_max_idx  = '0;
      m_max_val  = '0;
      m_pk_idx   = '0;
      m_pk_val   = '0;
      prev_stall = 1'b0;
    end
  end

  initial begin
    logic a;
    int   n, guard, fd0;
    int   re, im;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_peak_index", 128'(peak_index), 128'(0));
    chk("rst_peak_value", 128'(peak_value), 128'(0));

    // Ramp re=k: latency, back-to-back outputs, single frame_done, peak at bin 511
    arm_lat = 1'b1;
    arm_out = 1'b1;
    n_out = 0;
    fd0 = fd_count;
    for (int k = 0; k < 1024; k++) drive(1'b1, k, 0, POW_W'(k * k), 1'b0, a);
    drain();
    chk("ramp_latency", 128'(t_out - t_acc), 128'(3));
    chk("ramp_out_count", 128'(n_out), 128'(1024));
    chk("ramp_consecutive", 128'(t_last - t_out), 128'(1023));
    chk("ramp_frame_done_count", 128'(fd_count - fd0), 128'(1));
    chk("ramp_peak_index", 128'(peak_index), 128'(511));
    chk("ramp_peak_value", 128'(peak_value), 128'(261121));

    // Extremes: (-2^31,-2^31) -> 2^63, (1,-1) -> 2
    drive(1'b1, 32'sh8000_0000, 32'sh8000_0000, pow_t'(1) << 63, 1'b0, a);
    drive(1'b1, 1, -1, pow_t'(2), 1'b0, a);
    drain();

    // Peak frame after resync: DC and bin 700 excluded, bin 37 wins
    drive(1'b0, '0, '0, '0, 1'b1, a);
    for (int k = 0; k < 1024; k++) begin
      if (k == 0)        drive(1'b1, 9000, 0, pow_t'(81000000), 1'b0, a);
      else if (k == 37)  drive(1'b1, 1000, 0, pow_t'(1000000), 1'b0, a);
      else if (k == 700) drive(1'b1, 5000, 0, pow_t'(25000000), 1'b0, a);
      else               drive(1'b1, 0, 0, pow_t'(0), 1'b0, a);
    end
    drain();
    chk("peak37_index", 128'(peak_index), 128'(37));
    chk("peak37_value", 128'(peak_value), 128'(1000000));

    // Tie between bins 5 and 9 keeps the lower index
    for (int k = 0; k < 1024; k++) begin
      if (k == 5)      drive(1'b1, 4, 0, pow_t'(16), 1'b0, a);
      else if (k == 9) drive(1'b1, 0, -4, pow_t'(16), 1'b0, a);
      else             drive(1'b1, 0, 0, pow_t'(0), 1'b0, a);
    end
    drain();
    chk("tie_peak_index", 128'(peak_index), 128'(5));
    chk("tie_peak_value", 128'(peak_value), 128'(16));

    // Three frames with random valid and ready
    rdy_mode = 1;
    n = 0;
    guard = 0;
    fd0 = fd_count;
    while (n < 3 * 1024 && guard < 40000) begin
      re = int'($urandom_range(0, 60000)) - 30000;
      im = int'($urandom_range(0, 60000)) - 30000;
      drive(1'($urandom_range(0, 1)), re, im,
            POW_W'(longint'(re) * longint'(re) + longint'(im) * longint'(im)), 1'b0, a);
      if (a) n++;
      guard++;
    end
    chk("random_accepts", 128'(n), 128'(3 * 1024));
    drain();
    chk("random_frame_done_count", 128'(fd_count - fd0), 128'(3));

    // Resync on the 200th accept: frame restarts there
    fd0 = fd_count;
    for (int k = 0; k < 199 + 1 + 1023; k++)
      drive(1'b1, k, 0, POW_W'(k * k), (k == 199), a);
    drain();
    chk("resync_frame_done_count", 128'(fd_count - fd0), 128'(1));
    chk("resync_bin_counter_model", 128'(tb_bin), 128'(0));

    // Reset while stalled mid-frame
    for (int k = 0; k < 10; k++) drive(1'b1, k + 3, 2, POW_W'((k + 3) * (k + 3) + 4), 1'b0, a);
    rdy_mode = 2;
    for (int k = 0; k < 4; k++) drive(1'b1, 7, 7, pow_t'(98), 1'b0, a);
    chk("pre_reset_stalled", 128'(in_ready), 128'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    in_valid = 1'b0;
    resync = 1'b0;
    out_ready = 1'b0;
    tb_bin = '0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    rdy_mode = 0;
    @(negedge clk);
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    chk("reset_in_ready", 128'(in_ready), 128'(1));
    chk("reset_peak_index", 128'(peak_index), 128'(0));
    chk("reset_peak_value", 128'(peak_value), 128'(0));
    for (int k = 0; k < 5; k++) drive(1'b1, -k, k + 1, POW_W'(k * k + (k + 1) * (k + 1)), 1'b0, a);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_power_stage.md
# fft_power_stage

Converts the complex FFT output stream into a per-bin power stream for the LED display stage, and tracks the strongest positive-frequency bin in each frame. It sits directly between the FFT core and the LED bin-summing view, all on `slow_clk`. Each accepted complex sample becomes re² + im² on the output `dstream`, tagged with its bin index 0..N-1. A per-frame peak (bin index and power) is published at the end of every frame.

## Interface
- `N`, 1024: FFT length, power of two; bins per frame.
- `DATA_W`, 32: signed width of each of re and im.
- `POW_W`, 2*DATA_W+1 (65): unsigned power width; matches the display stage's `W`.
- `IDX_W`, $clog2(N) (10): bin index width.

Ports:
- `slow_clk`  in  1  18.432 MHz processing clock. This is the only clock.
- `reset_n`  in  1  Synchronous, active-low reset.
- `fft_in`  dstream.in  `data` 2*DATA_W  FFT output; `data` = {re, im}, both signed. Uses valid/ready; any incoming `index` is ignored.
- `fft_out`  dstream.out  `data` POW_W, `index` IDX_W  Power stream to the LED view.
- `resync`  in  1  Single-cycle pulse. Realigns the frame so that the next accepted sample is bin 0.
- `frame_done`  out  1  Single-cycle pulse when bin N-1 leaves on `fft_out`.
- `peak_index`  out  IDX_W  Strongest bin in the last completed frame.
- `peak_value`  out  POW_W  Power of `peak_index`.

## Operation
- **Accept:** a sample is accepted when `fft_in.valid & fft_in.ready`.
- **Bin counter:**
  - Counts accepted samples modulo N.
  - The accepted sample is tagged with the current count, then the count increments and wraps N-1 → 0.
- **`resync`:**
  - Counter returns to 0.
  - If a sample is accepted in the same cycle, that sample is tagged 0 and the counter becomes 1.
- **Pipeline (3 stages, sub-module `power_pipe`):**
  - S1 registers re, im and the index.
  - S2 forms the signed products re*re and im*im, each 2*DATA_W bits and non-negative.
  - S3 zero-extends both products to POW_W and adds them.
  - No saturation is needed: the maximum is 2·(2^(DATA_W-1))² = 2^(2*DATA_W-1), which fits in POW_W bits.
- **Backpressure:**
  - Global stall `stall = fft_out.valid & ~fft_out.ready`.
  - When stalled, every stage holds its contents.
  - `fft_in.ready = ~stall`.
  - No sample is dropped or duplicated.
- **Bubbles:** each stage carries a valid bit, so invalid stages are squeezed out on advance.
- **Peak tracker (runs on output transfers):**
  - Only bins 1..N/2-1 are searched; DC and negative frequencies are excluded.
  - Running max: on a transfer of bin 1, the running max is loaded unconditionally. For later bins it is replaced only when the new value is strictly greater, so ties keep the lower index.
  - On the transfer of bin N-1: `peak_index`/`peak_value` take the running max and `frame_done` pulses. Both peak outputs hold until the next frame end.
- **`resync` mid-frame:** samples already in the pipeline keep their old tags. The partial frame never produces a `frame_done`, except when an old-tagged bin N-1 is still in flight.

## Timing
- Latency is 3 cycles from accept to `fft_out.valid` when there is no stall; add one cycle per stalled cycle.
- Throughput is one sample per cycle with `fft_out.ready` held high.
- `frame_done` is high in the same cycle the bin N-1 transfer completes. `peak_*` update on the next clock edge, coincident with the end of the `frame_done` pulse.
- **Reset (`reset_n` low at a clock edge):**
  - All stage valids are 0, so `fft_out.valid` = 0.
  - Bin counter is 0.
  - `peak_index` = 0, `peak_value` = 0, `frame_done` = 0.
  - `fft_in.ready` = 1 from the first cycle after reset.
  - Reset mid-frame discards in-flight data with no partial `frame_done`.
- `fft_out.data`/`index` are don't-care while `fft_out.valid` = 0. They must stay stable while valid is high and ready is low.

## Structure
- Shared package `fft_pkg` holds:
  - `N`, `DATA_W`, `POW_W`, `IDX_W`;
  - typedef `cplx_t` = struct {signed re, im};
  - typedef `pow_t` = unsigned [POW_W-1:0].
- The LED view imports the same widths from `fft_pkg`.
- Sub-module `power_pipe`: the 3-stage valid/stall pipeline carrying data and index. The top level holds the bin counter, resync logic and the peak tracker.

## Test plan
- Ramp 1024 samples (re=k, im=0) with ready held 1 → output index k carries k², first output 3 cycles after the first accept, 1024 consecutive valids, `frame_done` on index 1023.
- Worst case re=im=-2^31 → `data` = 2^63. Also re=1, im=-1 → `data` = 2.
- One frame, bin 37 = (1000,0), bin 700 = (5000,0), DC = (9000,0), all others 0 → `peak_index` = 37, `peak_value` = 1,000,000. A second frame with bins 5 and 9 both power 16 → `peak_index` = 5.
- Toggle `fft_out.ready` randomly and `fft_in.valid` randomly over 3 frames → scoreboard sees exact in-order values and indices, no drops or duplicates, and stable outputs while stalled.
- `resync` pulsed coincident with the accept of the 200th sample → that sample is tagged 0, the next is tagged 1, and the next `frame_done` occurs at the output of the new bin 1023.
- Assert `reset_n` low during mid-frame streaming with outputs stalled → the next cycle shows valid = 0, peak outputs 0, and ready = 1; the restarted stream is tagged from 0.
